// File: rtl/dds_pkg.sv
// dds_pkg: shared types and widths for the DDS sequencer slice.
// Imported by the config interface, phase accumulator and top.
package dds_pkg;

  localparam int ADDR_W  = 16;
  localparam int FREQ_W  = 12;
  localparam int AMP_W   = 8;
  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
  } cfg_t;

endpackage

// File: rtl/dds_seq_ctrl_if.sv
// dds_seq_ctrl_if: valid/ready configuration bus into the sequencer.
// master = control front end, slave = dds_seq_ctrl.
interface dds_seq_ctrl_if;
  import dds_pkg::*;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [FREQ_W-1:0]  cfg_freq;
  logic [AMP_W-1:0]   cfg_amp;
  logic [PHASE_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_freq,
    output cfg_amp,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_freq,
    input  cfg_amp,
    input  cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase accumulator with carry-out wrap detect
// and phase-offset add producing the sine-table address.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W      = 16,
  parameter int FREQ_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [FREQ_W-1:0]  freq,
  input  logic [PHASE_W-1:0] phase,
  output logic [ADDR_W-1:0]  addr,
  output logic               carry
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] step;
  logic [ACC_W:0]   sum;

  assign step  = ACC_W'(freq) << FREQ_SHIFT;
  assign sum   = {1'b0, acc_q} + {1'b0, step};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum[ACC_W-1:0];
    end
  end

  // address is forced to 0 while idle, whatever the phase setting
  always_comb begin
    addr = '0;
    if (en) begin
      addr = acc_q[ACC_W-1 -: ADDR_W] +
             {phase, {(ADDR_W-PHASE_W){1'b0}}};
    end
  end

endmodule

// File: rtl/dds_seq_ctrl.sv
// dds_seq_ctrl: sequencer FSM with active/shadow config registers;
// RUN-time config is deferred to the accumulator wrap.
module dds_seq_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W          = 16,
  parameter int FREQ_SHIFT     = 0,
  parameter bit UPDATE_AT_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  dds_seq_ctrl_if.slave      cfg,
  output logic               gen_en,
  output logic [ADDR_W-1:0]  gen_addr,
  output logic [FREQ_W-1:0]  gen_freq,
  output logic [AMP_W-1:0]   gen_amp,
  output logic [PHASE_W-1:0] gen_phase,
  output logic               wrap_pulse,
  output logic               busy
);

  state_t state_q, state_d;
  cfg_t   act_q, act_d;
  cfg_t   sh_q, sh_d;
  cfg_t   word;
  logic   running, xfer, carry;
  logic   stop_go, start_go, acc_clr;
  logic   wrap_evt, frozen;

  assign running  = (state_q != IDLE);
  assign xfer     = cfg.cfg_valid & cfg.cfg_ready;
  assign word     = '{freq:  cfg.cfg_freq,
                      amp:   cfg.cfg_amp,
                      phase: cfg.cfg_phase};
  assign stop_go  = stop & running;
  assign start_go = start & ~stop;
  assign acc_clr  = start_go | stop_go;
  assign wrap_evt = running & carry & ~acc_clr;
  // zero step never wraps, so a pending word must not wait for one
  assign frozen   = (act_q.freq == '0);

  dds_phase_acc #(
    .ACC_W      (ACC_W),
    .FREQ_SHIFT (FREQ_SHIFT)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running),
    .clr   (acc_clr),
    .freq  (act_q.freq),
    .phase (act_q.phase),
    .addr  (gen_addr),
    .carry (carry)
  );

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (xfer)     act_d   = word;
        if (start_go) state_d = RUN;
      end
      RUN: begin
        if (stop_go) begin
          state_d = IDLE;
          if (xfer) act_d = word;
        end else if (xfer) begin
          if (UPDATE_AT_WRAP) begin
            sh_d    = word;
            state_d = PEND;
          end else begin
            act_d = word;
          end
        end
      end
      PEND: begin
        if (stop_go) begin
          state_d = IDLE;
          act_d   = sh_q;
        end else if (!start_go && (wrap_evt || frozen)) begin
          state_d = RUN;
          act_d   = sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      act_q      <= '0;
      sh_q       <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      sh_q       <= sh_d;
      wrap_pulse <= wrap_evt;
    end
  end

  assign cfg.cfg_ready = (state_q != PEND);
  assign gen_en        = running;
  assign busy          = running;
  assign gen_freq      = act_q.freq;
  assign gen_amp       = act_q.amp;
  assign gen_phase     = act_q.phase;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// tb_dds_seq_ctrl: scoreboard bench for dds_seq_ctrl (ACC_W=16).
// Expected per-cycle outputs are queued, then popped and compared.
module tb_dds_seq_ctrl;
  import dds_pkg::*;

  typedef struct packed {
    logic        en;
    logic        wrap;
    logic        rdy;
    logic [15:0] addr;
    logic [11:0] freq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        gen_en, wrap_pulse, busy;
  logic [15:0] gen_addr;
  logic [11:0] gen_freq;
  logic [7:0]  gen_amp, gen_phase;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  dds_seq_ctrl_if cfg();

  dds_seq_ctrl #(
    .ACC_W          (16),
    .FREQ_SHIFT     (0),
    .UPDATE_AT_WRAP (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cfg        (cfg),
    .gen_en     (gen_en),
    .gen_addr   (gen_addr),
    .gen_freq   (gen_freq),
    .gen_amp    (gen_amp),
    .gen_phase  (gen_phase),
    .wrap_pulse (wrap_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input logic v, input int f,
                         input int a, input int p);
    cfg.cfg_valid = v;
    cfg.cfg_freq  = f[11:0];
    cfg.cfg_amp   = a[7:0];
    cfg.cfg_phase = p[7:0];
  endtask

  task automatic push(input logic en, input logic wrap,
                      input logic rdy, input int addr,
                      input int freq);
    exp_t e;
    e.en   = en;
    e.wrap = wrap;
    e.rdy  = rdy;
    e.addr = addr[15:0];
    e.freq = freq[11:0];
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int k);
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk($sformatf("en@%0d", k),   gen_en,     e.en);
    chk($sformatf("wrap@%0d", k), wrap_pulse, e.wrap);
    chk($sformatf("rdy@%0d", k),  cfg.cfg_ready, e.rdy);
    chk($sformatf("addr@%0d", k), gen_addr,   e.addr);
    chk($sformatf("freq@%0d", k), gen_freq,   e.freq);
  endtask

  function automatic logic wrp(input int k, input int step,
                               input int k0);
    return (k > k0) && ((((k - k0) * step) % 65536) == 0);
  endfunction

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_en", gen_en, 1'b0);
    chk("idle_addr", gen_addr, 16'h0);
  endtask

  task automatic load_start(input int f, input int a, input int p);
    cfg_set(1'b1, f, a, p);
    tick();
    cfg.cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    cfg_set(1'b0, 0, 0, 0);
    #12;
    chk("rst_en", gen_en, 1'b0);
    chk("rst_wrap", wrap_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", cfg.cfg_ready, 1'b1);
    chk("rst_addr", gen_addr, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cfg_set(1'b1, 256, 8'h80, 0);
    tick();
    cfg.cfg_valid = 1'b0;
    chk("idle_load_freq", gen_freq, 12'd256);
    chk("idle_load_amp", gen_amp, 8'h80);
    chk("idle_load_addr", gen_addr, 16'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 520; k++)
      push(1'b1, wrp(k, 256, 1), 1'b1,
           (256 * (k - 1)) & 32'hFFFF, 256);
    for (int k = 1; k <= 520; k++) begin
      pop_chk(k);
      tick();
    end
    go_idle();

    load_start(1024, 8'h80, 8'h40);
    for (int k = 1; k <= 70; k++)
      push(1'b1, wrp(k, 1024, 1), 1'b1,
           (32'h4000 + 1024 * (k - 1)) & 32'hFFFF, 1024);
    for (int k = 1; k <= 70; k++) begin
      pop_chk(k);
      tick();
    end
    go_idle();

    load_start(256, 8'h80, 0);
    for (int k = 1; k <= 400; k++) begin
      if (k <= 256)
        push(1'b1, 1'b0, (k <= 100),
             (256 * (k - 1)) & 32'hFFFF, 256);
      else
        push(1'b1, (k == 257) || wrp(k, 512, 257), 1'b1,
             (512 * (k - 257)) & 32'hFFFF, 512);
    end
    for (int k = 1; k <= 400; k++) begin
      pop_chk(k);
      if (k == 100) cfg_set(1'b1, 512, 8'h80, 0);
      tick();
      cfg.cfg_valid = 1'b0;
    end
    go_idle();

    load_start(0, 8'h80, 0);
    for (int k = 1; k <= 12; k++)
      push(1'b1, 1'b0, (k != 4),
           (k < 5) ? 0 : 16 * (k - 5), (k <= 4) ? 0 : 16);
    for (int k = 1; k <= 12; k++) begin
      pop_chk(k);
      if (k == 3) cfg_set(1'b1, 16, 8'h80, 0);
      tick();
      cfg.cfg_valid = 1'b0;
    end
    go_idle();

    load_start(256, 8'h80, 0);
    for (int k = 1; k <= 12; k++)
      push(1'b1, 1'b0, (k <= 10),
           (256 * (k - 1)) & 32'hFFFF, 256);
    for (int k = 1; k <= 12; k++) begin
      pop_chk(k);
      if (k == 10) cfg_set(1'b1, 77, 8'h11, 8'h22);
      if (k == 12) stop = 1'b1;
      tick();
      cfg.cfg_valid = 1'b0;
      stop = 1'b0;
    end
    chk("pstop_en", gen_en, 1'b0);
    chk("pstop_addr", gen_addr, 16'h0);
    chk("pstop_freq", gen_freq, 12'd77);
    chk("pstop_amp", gen_amp, 8'h11);
    chk("pstop_phase", gen_phase, 8'h22);
    chk("pstop_rdy", cfg.cfg_ready, 1'b1);
    chk("pstop_busy", busy, 1'b0);
    chk("pstop_wrap", wrap_pulse, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (k <= 5) ? k - 1 : k - 6;
      push(1'b1, 1'b0, 1'b1,
           (32'h2200 + 77 * j) & 32'hFFFF, 77);
    end
    for (int k = 1; k <= 8; k++) begin
      pop_chk(k);
      if (k == 5) start = 1'b1;
      if (k == 8) begin
        start = 1'b1;
        stop  = 1'b1;
      end
      tick();
      start = 1'b0;
      stop  = 1'b0;
    end
    chk("ss_busy", busy, 1'b0);
    chk("ss_en", gen_en, 1'b0);
    chk("ss_addr", gen_addr, 16'h0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 3) cfg_set(1'b1, 500, 8'h33, 8'h44);
      tick();
      cfg.cfg_valid = 1'b0;
    end
    chk("pend_rdy", cfg.cfg_ready, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_en", gen_en, 1'b0);
    chk("arst_addr", gen_addr, 16'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rdy", cfg.cfg_ready, 1'b1);
    chk("arst_freq", gen_freq, 12'd0);
    chk("arst_amp", gen_amp, 8'h0);
    chk("arst_phase", gen_phase, 8'h0);
    chk("arst_wrap", wrap_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_freq", gen_freq, 12'd0);
    chk("rel_rdy", cfg.cfg_ready, 1'b1);
    chk("rel_en", gen_en, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_seq_ctrl.md
Name: dds_seq_ctrl

Overview:
- Sequencer for the sine-table generator: owns the phase accumulator that drives the 16-bit table address, plus its enable and frequency/amplitude/phase settings.
- Accepts configuration through a valid/ready handshake.
- While running, parameter changes are deferred to a waveform-cycle boundary (accumulator wrap) so the output stays glitch-free.
- Sits between the control front end (keys/UART decoder) and the sine generator.

Parameters:
- ACC_W, 16, accumulator width; gen_addr is the top 16 bits (ACC_W >= 16).
- FREQ_SHIFT, 0, step = cfg_freq << FREQ_SHIFT, zero-extended to ACC_W.
- UPDATE_AT_WRAP, 1, 1 = apply RUN-time config at wrap; 0 = apply next cycle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: start/restart the waveform
- stop  in  1  one-cycle pulse: stop the waveform
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config can be accepted
- cfg_freq  in  12  frequency control word
- cfg_amp  in  8  amplitude setting
- cfg_phase  in  8  phase offset, 1/256 cycle units
- gen_en  out  1  generator output enable
- gen_addr  out  16  table address to generator
- gen_freq  out  12  active frequency word
- gen_amp  out  8  active amplitude
- gen_phase  out  8  active phase
- wrap_pulse  out  1  one-cycle pulse per accumulator wrap
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, active and shadow registers 0.
  - gen_en=0, wrap_pulse=0, busy=0, cfg_ready=1, gen_addr=0.
- States: IDLE, RUN, PEND (shadow config waiting for wrap).
- Transfer: a config word transfers on cfg_valid & cfg_ready at the rising edge.
- IDLE:
  - A transfer loads the active registers at that edge; cfg_ready stays 1.
  - start -> RUN at next edge with acc=0; gen_en=1 from that cycle.
  - gen_addr=0.
- RUN:
  - acc <= acc + step every cycle, modulo 2^ACC_W.
  - gen_addr = acc[ACC_W-1:ACC_W-16] + {gen_phase, 8'h00}, modulo 2^16, combinational from registers.
  - First RUN cycle therefore shows gen_addr = phase<<8.
- Wrap:
  - Occurs when acc + step carries out of ACC_W.
  - wrap_pulse is registered and high for exactly the cycle after that edge.
- Transfer in RUN with UPDATE_AT_WRAP=1:
  - Word is captured into the shadow; cfg_ready=0 next cycle; -> PEND.
- Transfer in RUN with UPDATE_AT_WRAP=0:
  - Active registers load at the edge; state stays RUN.
- PEND:
  - acc keeps running on the old step.
  - At the wrapping edge: shadow -> active, state -> RUN, cfg_ready=1 next cycle.
  - New step takes effect from the following addition.
- Zero frequency:
  - If active freq==0 in PEND, no wrap can occur.
  - Shadow applies at the next edge instead (no deadlock).
- stop in RUN/PEND:
  - -> IDLE at next edge; acc=0, gen_en=0, wrap_pulse=0.
  - A pending shadow is applied (not discarded); cfg_ready=1.
- start in RUN/PEND:
  - acc cleared to 0 (phase restart); state and pending shadow unchanged.
  - No wrap_pulse is generated.
- Simultaneous start & stop: stop wins.
- Simultaneous wrap and transfer in RUN: the word goes to the shadow and waits for the next wrap.
- stop/start in IDLE: stop ignored.
- Reset mid-operation: immediate return to reset values; pending shadow lost.
- gen_freq/gen_amp/gen_phase always reflect the active registers.

Decomposition:
- Shared package/header dds_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, PEND=2'd2).
  - ADDR_W=16, FREQ_W=12, AMP_W=8, PHASE_W=8.
- Sub-module dds_phase_acc:
  - Accumulator register, step add, carry-out wrap detect, synchronous clear.
  - Phase-offset add.
- FSM and shadow/active registers stay in the top.

Test Plan:
- Reset, cfg freq=256 amp=0x80 phase=0, start -> gen_addr 0,256,512,... (ACC_W=16); wrap_pulse at cycle 257 after start, then every 256 cycles.
- phase=0x40, freq=1024, start -> first gen_addr=0x4000, then 0x4400; 0xFC00 wraps to 0x0000.
- RUN freq=256; at cycle 100 send freq=512 -> cfg_ready=0, step stays 256 until wrap at cycle 256; step 512 after; cfg_ready=1 the cycle after wrap.
- Active freq=0 in RUN, send freq=16 -> applied next edge, cfg_ready back to 1 within 2 cycles; gen_addr advances by 16.
- In PEND assert stop -> gen_en=0 and gen_addr=0 next cycle, gen_freq=shadow value; start and stop together in RUN -> IDLE.
- rst_n low mid-PEND (asynchronous, between edges) -> all outputs at reset values immediately; after release, gen_freq=0 and cfg_ready=1.
